alu_fifo_engine: RTL and testbench

ALU_FIFO_ENGINE -- requirements
Module: alu_fifo_engine

---
 rtl/alu_fifo_engine.sv | 115 +++++++++++
 tb/tb_alu_fifo_engine.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_fifo_engine.sv
// Command engine: pops opcode/A/B triples from the CL-to-ALU FIFO and pushes one ALU result
// per command into the ALU-to-CL FIFO, with result and illegal-opcode counters.
module alu_fifo_engine #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_main_a0,
    input  logic                  rst_main_n_sync,
    output logic                  fifo_cl_to_alu_rd,
    input  logic [DATA_WIDTH-1:0] fifo_cl_to_alu_dout,
    input  logic                  fifo_cl_to_alu_empty,
    output logic                  fifo_alu_to_cl_wr,
    output logic [DATA_WIDTH-1:0] fifo_alu_to_cl_din,
    input  logic                  fifo_alu_to_cl_full,
    output logic                  busy,
    output logic [15:0]           cmd_count,
    output logic [15:0]           err_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        CAPTURE = 3'd3,
        EXEC    = 3'd4,
        WR_OUT  = 3'd5
    } state_t;

    state_t                state, state_next;
    logic [1:0]            idx;
    logic [3:0]            opcode;
    logic [DATA_WIDTH-1:0] op_a, op_b, result;
    logic [DATA_WIDTH-1:0] alu_out;
    logic                  alu_illegal;
    logic                  rd_next, wr_next;
    logic [DATA_WIDTH-1:0] din_next;

    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) state <= IDLE;
        else                  state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_cl_to_alu_empty) state_next = RD_REQ;
            RD_REQ:  if (!fifo_cl_to_alu_empty) state_next = RD_WAIT;
            RD_WAIT: state_next = CAPTURE;
            CAPTURE: state_next = (idx == 2'd2) ? EXEC : RD_REQ;
            EXEC:    state_next = WR_OUT;
            WR_OUT:  if (!fifo_alu_to_cl_full) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The strobes are registered, so rd is visible during RD_WAIT and the FIFO
    // pops on the edge closing it, presenting dout while in CAPTURE.
    always_comb begin
        rd_next  = (state == RD_REQ) && !fifo_cl_to_alu_empty;
        wr_next  = (state == WR_OUT) && !fifo_alu_to_cl_full;
        din_next = wr_next ? result : '0;
    end

    always_comb begin
        alu_illegal = 1'b0;
        alu_out     = '1;
        case (opcode)
            4'd0: alu_out = op_a + op_b;
            4'd1: alu_out = op_a - op_b;
            4'd2: alu_out = op_a & op_b;
            4'd3: alu_out = op_a | op_b;
            4'd4: alu_out = op_a ^ op_b;
            4'd5: alu_out = op_a << op_b[4:0];
            4'd6: alu_out = op_a >> op_b[4:0];
            4'd7: alu_out = ($signed(op_a) < $signed(op_b)) ? DATA_WIDTH'(1) : '0;
            4'd8: alu_out = op_a * op_b;
            default: alu_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            idx                <= '0;
            opcode             <= '0;
            op_a               <= '0;
            op_b               <= '0;
            result             <= '0;
            fifo_cl_to_alu_rd  <= 1'b0;
            fifo_alu_to_cl_wr  <= 1'b0;
            fifo_alu_to_cl_din <= '0;
            cmd_count          <= '0;
            err_count          <= '0;
        end else begin
            fifo_cl_to_alu_rd  <= rd_next;
            fifo_alu_to_cl_wr  <= wr_next;
            fifo_alu_to_cl_din <= din_next;
            if (state == IDLE) idx <= '0;
            if (state == CAPTURE) begin
                case (idx)
                    2'd0:    opcode <= fifo_cl_to_alu_dout[3:0];
                    2'd1:    op_a   <= fifo_cl_to_alu_dout;
                    default: op_b   <= fifo_cl_to_alu_dout;
                endcase
                if (idx != 2'd2) idx <= idx + 2'd1;
            end
            if (state == EXEC) begin
                result <= alu_out;
                if (alu_illegal) err_count <= err_count + 16'd1;
            end
            if (wr_next) cmd_count <= cmd_count + 16'd1;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_fifo_engine.sv
// Scoreboard bench for alu_fifo_engine: behavioural input FIFO, controllable output-full flag,
// directed commands with hand-computed results checked by an independent monitor.
module tb_alu_fifo_engine;

    typedef struct {
        logic [31:0] data;
        logic [15:0] cmd;
        logic [15:0] err;
    } exp_t;

    typedef struct {
        logic [31:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        illegal;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd, wr, empty, busy;
    logic        full = 1'b0;
    logic [31:0] dout = '0;
    logic [31:0] din;
    logic [15:0] cmd_count, err_count;

    logic [31:0] in_mem [0:255];
    int unsigned wptr = 0;
    int unsigned rptr = 0;

    exp_t        exp_q[$];
    int          checks = 0;
    int          fails = 0;
    int          rd_pulses = 0;
    int          cyc = 0;
    int          last_rd = -100;
    logic [15:0] exp_cmd = '0;
    logic [15:0] exp_err = '0;

    always #5 clk = ~clk;

    alu_fifo_engine #(.DATA_WIDTH(32)) dut (
        .clk_main_a0          (clk),
        .rst_main_n_sync      (rst_n),
        .fifo_cl_to_alu_rd    (rd),
        .fifo_cl_to_alu_dout  (dout),
        .fifo_cl_to_alu_empty (empty),
        .fifo_alu_to_cl_wr    (wr),
        .fifo_alu_to_cl_din   (din),
        .fifo_alu_to_cl_full  (full),
        .busy                 (busy),
        .cmd_count            (cmd_count),
        .err_count            (err_count)
    );

    assign empty = (wptr == rptr);

    always @(posedge clk) begin
        if (rd && (wptr != rptr)) begin
            dout <= in_mem[rptr % 256];
            rptr <= rptr + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: independent of stimulus, pops the scoreboard on every write strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (wr) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", din, 32'hDEAD_BEEF ^ din ^ 32'h1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", din, e.data);
                    check("cmd_count", {16'h0, cmd_count}, {16'h0, e.cmd});
                    check("err_count", {16'h0, err_count}, {16'h0, e.err});
                end
                check("write_while_full", {31'h0, full}, 32'h0);
            end else begin
                check("din_idle_zero", din, 32'h0);
            end
            if (rd) begin
                rd_pulses++;
                check("rd_while_empty", {31'h0, empty}, 32'h0);
                check("rd_spacing_ok", {31'h0, (cyc - last_rd) >= 3}, 32'h1);
                last_rd = cyc;
            end
        end
    end

    task automatic push_word(input logic [31:0] w);
        in_mem[wptr % 256] = w;
        wptr = wptr + 1;
    endtask

    task automatic expect_result(input logic [31:0] res, input logic illegal);
        exp_t e;
        exp_cmd = exp_cmd + 16'd1;
        if (illegal) exp_err = exp_err + 16'd1;
        e.data = res;
        e.cmd  = exp_cmd;
        e.err  = exp_err;
        exp_q.push_back(e);
    endtask

    task automatic issue(input vec_t v);
        expect_result(v.res, v.illegal);
        push_word(v.op);
        push_word(v.a);
        push_word(v.b);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 300) begin
            step(1);
            budget++;
        end
        check(name, exp_q.size(), 32'h0);
        step(4);
    endtask

    task automatic wait_rd(input int target);
        int budget;
        budget = 0;
        while (rd_pulses < target && budget < 200) begin
            step(1);
            budget++;
        end
        check("rd_wait_timeout", {31'h0, rd_pulses >= target}, 32'h1);
    endtask

    vec_t vecs [13];

    initial begin
        int base;
        vecs[0]  = '{32'h0,         32'h5,         32'h3,         32'h8,         1'b0};
        vecs[1]  = '{32'h1,         32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{32'h7,         32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0};
        vecs[3]  = '{32'h5,         32'h1,         32'h24,        32'h10,        1'b0};
        vecs[4]  = '{32'hC,         32'h1,         32'h2,         32'hFFFF_FFFF, 1'b1};
        vecs[5]  = '{32'h2,         32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0};
        vecs[6]  = '{32'h3,         32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0};
        vecs[7]  = '{32'h4,         32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0};
        vecs[8]  = '{32'h6,         32'h8000_0000, 32'h0000_003F, 32'h1,         1'b0};
        vecs[9]  = '{32'h8,         32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 1'b0};
        vecs[10] = '{32'h0,         32'hFFFF_FFFF, 32'h2,         32'h1,         1'b0};
        vecs[11] = '{32'hFFFF_FFF2, 32'h0000_00FF, 32'h0000_000F, 32'h0000_000F, 1'b0};
        vecs[12] = '{32'h7,         32'h1,         32'hFFFF_FFFF, 32'h0,         1'b0};

        step(3);
        check("reset_rd", {31'h0, rd}, 32'h0);
        check("reset_wr", {31'h0, wr}, 32'h0);
        check("reset_din", din, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_cmd_count", {16'h0, cmd_count}, 32'h0);
        check("reset_err_count", {16'h0, err_count}, 32'h0);
        rst_n = 1'b1;
        step(2);

        for (int i = 0; i < 13; i++) begin
            issue(vecs[i]);
            drain("drain_vec");
        end

        // Back-to-back commands queued at once, including an illegal opcode mid-stream
        issue('{32'hF, 32'h7, 32'h9, 32'hFFFF_FFFF, 1'b1});
        issue('{32'h1, 32'h3, 32'h5, 32'hFFFF_FFFE, 1'b0});
        drain("drain_b2b");

        // Output FIFO full while a result is pending
        full = 1'b1;
        issue('{32'h0, 32'h10, 32'h20, 32'h30, 1'b0});
        step(15);
        check("full_busy", {31'h0, busy}, 32'h1);
        issue('{32'h4, 32'hFF, 32'h0F, 32'hF0, 1'b0});
        base = rd_pulses;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("full_no_wr", {31'h0, wr}, 32'h0);
        end
        check("full_no_reads", rd_pulses - base, 32'h0);
        full = 1'b0;
        drain("drain_full");

        // Input starvation after opcode and A
        expect_result(32'h0000_1234, 1'b0);
        base = rd_pulses;
        push_word(32'h3);
        push_word(32'h0000_1230);
        wait_rd(base + 2);
        step(3);
        base = rd_pulses;
        for (int i = 0; i < 50; i++) begin
            step(1);
            check("stall_busy", {31'h0, busy}, 32'h1);
        end
        check("stall_no_rd", rd_pulses - base, 32'h0);
        push_word(32'h0000_0004);
        drain("drain_stall");

        // Reset while capturing A: partial command discarded
        base = rd_pulses;
        push_word(32'h0);
        push_word(32'h1111_1111);
        wait_rd(base + 2);
        step(1);
        rst_n = 1'b0;
        #1;
        check("rst_rd", {31'h0, rd}, 32'h0);
        check("rst_wr", {31'h0, wr}, 32'h0);
        check("rst_din", din, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_cmd_count", {16'h0, cmd_count}, 32'h0);
        check("rst_err_count", {16'h0, err_count}, 32'h0);
        exp_cmd = '0;
        exp_err = '0;
        step(2);
        rst_n = 1'b1;
        step(1);
        issue('{32'h1, 32'h64, 32'h14, 32'h50, 1'b0});
        drain("drain_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
